sm4_key_expansion: RTL
======================

# sm4_key_expansion

Iterative SM4 key schedule. Takes a 128-bit cipher key and produces the 32 round keys `rk_00`..`rk_31` plus the `key_exp_ready` handshake. These feed the 32-stage SM4 encrypt/decrypt pipeline. The block computes one round key per cycle, and for decryption it stores the keys in reversed order so the datapath needs no reordering.

## Interface
- No parameters.
- `clk`  input  1  sole clock, rising edge.
- `reset`  input  1  synchronous, active-high; clears all state and outputs.
- `sm4_enable_in`  input  1  global enable; when low, the FSM, counter and all registers hold.
- `key_exp_enable_in`  input  1  level request; starts an expansion in IDLE; must drop to leave DONE.
- `decrypt_in`  input  1  order select, sampled at start: 1 = reversed round-key order.
- `key_in`  input  128  cipher key MK0..MK3, with MK0 in `[127:96]`; sampled at start.
- `key_exp_ready_out`  output  1  high while in DONE, meaning `rk_*_out` are valid and stable.
- `rk_00_out` … `rk_31_out`  output  32 each  round-key registers.

## Operation
- FSM states: IDLE (00), EXPAND (01), DONE (10). Any other encoding goes to IDLE on the next enabled edge.
- Every transition requires `sm4_enable_in`=1.
- **IDLE → EXPAND** when `key_exp_enable_in`=1. On that edge:
  - K0..K3 <= `key_in` ^ FK, with FK = A3B1BAC6_56AA3350_677D9197_B27022DC.
  - `cnt` <= 0.
  - `dec_q` <= `decrypt_in`.
- **EXPAND**, each enabled edge:
  - rk = K0 ^ T'(K1^K2^K3^CK[cnt]).
  - Shift {K0,K1,K2,K3} <= {K1,K2,K3,rk}.
  - Write rk to slot `cnt`, or to slot 31-`cnt` when `dec_q`=1.
  - `cnt`++.
- **EXPAND → DONE** on the edge that writes `cnt`=31. `cnt` is 5 bits and wraps to 0, which is harmless.
- **DONE → IDLE** when `key_exp_enable_in`=0. Otherwise the FSM stays in DONE.
- T'(x) = L'(τ(x)), where τ applies the SM4 S-box to each byte and L'(B) = B ^ (B<<<13) ^ (B<<<23).
- CK[i] byte j = ((4i+j)·7) mod 256; byte j=0 is the MSB.
- Round-key registers keep their last values outside EXPAND. A new expansion overwrites them slot by slot.
- `key_exp_enable_in` and `key_in` changes during EXPAND are ignored; the key was already latched.
- A `key_exp_enable_in` drop during EXPAND does not abort. The block reaches DONE and then exits immediately on the next enabled edge.

## Timing
- Reset, and the first cycle after reset deasserts: state IDLE, `cnt`=0, K=0, all `rk_*_out`=0, `key_exp_ready_out`=0.
- Start sampled at edge E0. Slot writes occur at edges E1..E32. `key_exp_ready_out` rises after E32, so 32 cycles of latency.
- `rk_*_out` are registered and stable for the whole time `key_exp_ready_out`=1.
- `sm4_enable_in` low for n cycles during EXPAND delays ready by exactly n cycles and corrupts nothing.
- Reset asserted mid-EXPAND returns the block to IDLE with all outputs 0 on the next edge. Reset wins over every other event.
- `key_exp_ready_out` is a registered decode of the state, so it has no combinational path from inputs.

## Configuration
- Macro: `SM4_KEY_DEC_REVERSE_EN`.
- Defined: `decrypt_in` is honoured as described in Operation.
- Undefined: `decrypt_in` is still a port but is ignored. `dec_q` is tied to 0, so slots are always written in natural order. Decryption callers must then reorder the keys externally.

## Structure
- Package `sm4_pkg` holds:
  - the FSM state constants IDLE/EXPAND/DONE;
  - the FK constant;
  - a CK function or constant table;
  - the S-box byte table as a function.
- Sub-module `sm4_key_tprime`: a combinational 32→32 T' (4 S-box lookups plus L'). It is instantiated once and shared across iterations.
- Top-level contents: the FSM, the 5-bit counter, the K0..K3 shift registers, and 32×32 round-key registers with a slot decoder.

## Test plan
- Key 0123456789ABCDEF_FEDCBA9876543210, `decrypt_in`=0 → ready after 32 cycles; `rk_00_out`=F12186F9, `rk_01_out`=41662B61, `rk_31_out`=9124A012.
- Same key, `decrypt_in`=1 (macro defined) → `rk_00_out`=9124A012, `rk_30_out`=41662B61, `rk_31_out`=F12186F9. With the macro undefined → natural order, as in the first scenario.
- `sm4_enable_in` held low for 5 cycles mid-EXPAND → ready rises exactly 37 cycles after start, with the round keys unchanged from the first scenario.
- Reset pulsed at EXPAND cycle 10 → next cycle: ready=0 and all `rk_*_out`=0. A restart then completes correctly in 32 cycles.
- In DONE, keep `key_exp_enable_in` high and change `key_in` → ready stays 1 and the round keys are unchanged. Drop the enable, then re-raise it with key 0 → new round keys, with `rk_00_out`=0 ^ FK0 ^ T'(FK1^FK2^FK3^CK[0]) matching the reference model.
- Back-to-back requests: `key_exp_enable_in` low for 1 cycle between runs → DONE → IDLE → EXPAND with no lost cycle and ready low for exactly 33 cycles.

Source files
------------

// File: rtl/sm4_pkg.sv
// rtl/sm4_pkg.sv - SM4 key schedule constants: FSM states, FK, CK generator and S-box
package sm4_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXPAND = 2'b01,
        DONE   = 2'b10
    } sm4_state_t;

    localparam logic [127:0] SM4_FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    // Element 0 is the leftmost byte, so SM4_SBOX[x] is a direct lookup.
    localparam logic [0:255][7:0] SM4_SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] sm4_sbox(input logic [7:0] x);
        return SM4_SBOX[x];
    endfunction

    // CK[i] byte j = (4i+j)*7 mod 256; 8-bit arithmetic gives the modulo for free.
    function automatic logic [31:0] sm4_ck(input logic [4:0] i);
        logic [7:0] base;
        base = {1'b0, i, 2'b00};
        return {(base + 8'd0) * 8'd7, (base + 8'd1) * 8'd7,
                (base + 8'd2) * 8'd7, (base + 8'd3) * 8'd7};
    endfunction

endpackage

// File: rtl/sm4_key_tprime.sv
// rtl/sm4_key_tprime.sv - combinational key-schedule T' transform (byte S-box then L')
module sm4_key_tprime
    import sm4_pkg::*;
(
    input  logic [31:0] x,
    output logic [31:0] y
);

    logic [31:0] b;

    assign b = {sm4_sbox(x[31:24]), sm4_sbox(x[23:16]), sm4_sbox(x[15:8]), sm4_sbox(x[7:0])};
    assign y = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};

endmodule

// File: rtl/sm4_key_expansion.sv
// rtl/sm4_key_expansion.sv - iterative SM4 round-key generator; SM4_KEY_DEC_REVERSE_EN enables reversed slot order
module sm4_key_expansion
    import sm4_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         sm4_enable_in,
    input  logic         key_exp_enable_in,
    input  logic         decrypt_in,
    input  logic [127:0] key_in,
    output logic         key_exp_ready_out,
    output logic [31:0]  rk_00_out,
    output logic [31:0]  rk_01_out,
    output logic [31:0]  rk_02_out,
    output logic [31:0]  rk_03_out,
    output logic [31:0]  rk_04_out,
    output logic [31:0]  rk_05_out,
    output logic [31:0]  rk_06_out,
    output logic [31:0]  rk_07_out,
    output logic [31:0]  rk_08_out,
    output logic [31:0]  rk_09_out,
    output logic [31:0]  rk_10_out,
    output logic [31:0]  rk_11_out,
    output logic [31:0]  rk_12_out,
    output logic [31:0]  rk_13_out,
    output logic [31:0]  rk_14_out,
    output logic [31:0]  rk_15_out,
    output logic [31:0]  rk_16_out,
    output logic [31:0]  rk_17_out,
    output logic [31:0]  rk_18_out,
    output logic [31:0]  rk_19_out,
    output logic [31:0]  rk_20_out,
    output logic [31:0]  rk_21_out,
    output logic [31:0]  rk_22_out,
    output logic [31:0]  rk_23_out,
    output logic [31:0]  rk_24_out,
    output logic [31:0]  rk_25_out,
    output logic [31:0]  rk_26_out,
    output logic [31:0]  rk_27_out,
    output logic [31:0]  rk_28_out,
    output logic [31:0]  rk_29_out,
    output logic [31:0]  rk_30_out,
    output logic [31:0]  rk_31_out
);

    sm4_state_t  state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] k_q [4];
    logic [31:0] rk_q [32];
    logic        dec_q;
    logic        ready_q;
    logic        start;
    logic [31:0] t_in, t_out, rk_new;
    logic [4:0]  slot;

    assign start  = (state_q == IDLE) && key_exp_enable_in;
    assign t_in   = k_q[1] ^ k_q[2] ^ k_q[3] ^ sm4_ck(cnt_q);
    assign rk_new = k_q[0] ^ t_out;
    assign slot   = dec_q ? (5'd31 - cnt_q) : cnt_q;

    sm4_key_tprime u_tprime (
        .x (t_in),
        .y (t_out)
    );

`ifdef SM4_KEY_DEC_REVERSE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_q <= 1'b0;
        end else if (sm4_enable_in && start) begin
            dec_q <= decrypt_in;
        end
    end
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt_in;
    assign dec_q          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (sm4_enable_in) begin
            case (state_q)
                IDLE:    if (key_exp_enable_in) state_d = EXPAND;
                EXPAND:  if (cnt_q == 5'd31) state_d = DONE;
                DONE:    if (!key_exp_enable_in) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            for (int i = 0; i < 4; i++) k_q[i] <= '0;
            for (int i = 0; i < 32; i++) rk_q[i] <= '0;
        end else if (sm4_enable_in) begin
            state_q <= state_d;
            // Ready is a registered decode of the next state, so it tracks DONE exactly.
            ready_q <= (state_d == DONE);
            if (start) begin
                k_q[0] <= key_in[127:96] ^ SM4_FK[127:96];
                k_q[1] <= key_in[95:64]  ^ SM4_FK[95:64];
                k_q[2] <= key_in[63:32]  ^ SM4_FK[63:32];
                k_q[3] <= key_in[31:0]   ^ SM4_FK[31:0];
                cnt_q  <= '0;
            end else if (state_q == EXPAND) begin
                k_q[0]     <= k_q[1];
                k_q[1]     <= k_q[2];
                k_q[2]     <= k_q[3];
                k_q[3]     <= rk_new;
                rk_q[slot] <= rk_new;
                cnt_q      <= cnt_q + 5'd1;
            end
        end
    end

    assign key_exp_ready_out = ready_q;
    assign rk_00_out = rk_q[0];
    assign rk_01_out = rk_q[1];
    assign rk_02_out = rk_q[2];
    assign rk_03_out = rk_q[3];
    assign rk_04_out = rk_q[4];
    assign rk_05_out = rk_q[5];
    assign rk_06_out = rk_q[6];
    assign rk_07_out = rk_q[7];
    assign rk_08_out = rk_q[8];
    assign rk_09_out = rk_q[9];
    assign rk_10_out = rk_q[10];
    assign rk_11_out = rk_q[11];
    assign rk_12_out = rk_q[12];
    assign rk_13_out = rk_q[13];
    assign rk_14_out = rk_q[14];
    assign rk_15_out = rk_q[15];
    assign rk_16_out = rk_q[16];
    assign rk_17_out = rk_q[17];
    assign rk_18_out = rk_q[18];
    assign rk_19_out = rk_q[19];
    assign rk_20_out = rk_q[20];
    assign rk_21_out = rk_q[21];
    assign rk_22_out = rk_q[22];
    assign rk_23_out = rk_q[23];
    assign rk_24_out = rk_q[24];
    assign rk_25_out = rk_q[25];
    assign rk_26_out = rk_q[26];
    assign rk_27_out = rk_q[27];
    assign rk_28_out = rk_q[28];
    assign rk_29_out = rk_q[29];
    assign rk_30_out = rk_q[30];
    assign rk_31_out = rk_q[31];

endmodule
